// File: rtl/axis_ascii_int_parser_if.sv
// axi_stream_if: minimal AXI-Stream bundle (tvalid/tready/tdata/tlast) with master/slave modports
interface axi_stream_if #(parameter int DATA_WIDTH = 8);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_ascii_int_parser.sv
// axis_ascii_int_parser: turns an ASCII byte stream into unsigned decimal integers, tlast on the frame's last value
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset
//   s_axis : 8-bit ASCII bytes in (tvalid/tdata/tlast in, tready out)
//   m_axis : VALUE_WIDTH-bit integers out (tvalid/tdata/tlast out, tready in)
//   AXIS_INT_PARSER_SIGNED_EN : when defined, a leading '-' makes the following number negative
module axis_ascii_int_parser #(
  parameter int VALUE_WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  axi_stream_if.slave  s_axis,
  axi_stream_if.master m_axis
);
  typedef enum logic {RUN, FLUSH} state_e;
  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d, hold_q, hold_d, out_q, out_d;
  logic [VALUE_WIDTH-1:0] acc_nxt, cur_acc, value;
  logic                   in_num_q, in_num_d, hold_valid_q, hold_valid_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   out_free, take, is_digit, complete;
`ifdef AXIS_INT_PARSER_SIGNED_EN
  logic                   neg_q, neg_d, neg_pending_q, neg_pending_d, neg_cur, is_dash;
`endif
  assign out_free      = !out_valid_q || m_axis.tready;
  assign s_axis.tready = rst_n && state_q == RUN && out_free;
  assign take          = s_axis.tvalid && s_axis.tready;
  assign is_digit      = s_axis.tdata >= 8'h30 && s_axis.tdata <= 8'h39;
  assign acc_nxt       = acc_q * VALUE_WIDTH'(10) + VALUE_WIDTH'(s_axis.tdata[3:0]);
  assign cur_acc       = is_digit ? acc_nxt : acc_q;
  // a digit only completes a number when it is the frame's last byte
  assign complete      = is_digit ? s_axis.tlast : in_num_q;
`ifdef AXIS_INT_PARSER_SIGNED_EN
  assign is_dash = s_axis.tdata == 8'h2D;
  assign neg_cur = is_digit && !in_num_q ? neg_pending_q : neg_q;
  assign value   = neg_cur ? VALUE_WIDTH'(0) - cur_acc : cur_acc;
`else
  assign value   = cur_acc;
`endif
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_q;
  assign m_axis.tlast  = out_last_q;
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    in_num_d     = in_num_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    out_d        = out_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q && !m_axis.tready;
`ifdef AXIS_INT_PARSER_SIGNED_EN
    neg_d         = neg_q;
    neg_pending_d = neg_pending_q;
`endif
    if (state_q == FLUSH) begin
      if (out_free) begin
        out_d        = hold_q;
        out_last_d   = 1'b1;
        out_valid_d  = 1'b1;
        hold_valid_d = 1'b0;
        state_d      = RUN;
      end
    end else if (take) begin
      acc_d    = is_digit && !s_axis.tlast ? acc_nxt : '0;
      in_num_d = is_digit && !s_axis.tlast;
      // the held value leaves whenever something newer completes or the frame ends
      if (hold_valid_q && (complete || s_axis.tlast)) begin
        out_d       = hold_q;
        out_valid_d = 1'b1;
        out_last_d  = s_axis.tlast && !complete;
      end else if (complete && s_axis.tlast) begin
        out_d       = value;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
      end
      if (complete) hold_d = value;
      hold_valid_d = s_axis.tlast ? hold_valid_q && complete : hold_valid_q || complete;
      // held value and a fresh final value both pending: the final one goes out next cycle
      state_d      = s_axis.tlast && hold_valid_q && complete ? FLUSH : RUN;
`ifdef AXIS_INT_PARSER_SIGNED_EN
      neg_d         = !(complete || s_axis.tlast) && neg_cur;
      neg_pending_d = !s_axis.tlast && is_dash;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      in_num_q     <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
`ifdef AXIS_INT_PARSER_SIGNED_EN
      neg_q         <= 1'b0;
      neg_pending_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      in_num_q     <= in_num_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
`ifdef AXIS_INT_PARSER_SIGNED_EN
      neg_q         <= neg_d;
      neg_pending_q <= neg_pending_d;
`endif
    end
  end
endmodule

// File: tb/tb_axis_ascii_int_parser.sv
// tb_axis_ascii_int_parser: random and directed frames checked against a frame-level parsing model
module tb_axis_ascii_int_parser;
  typedef byte bq_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_stream_if #(.DATA_WIDTH(8))  s_if();
  axi_stream_if #(.DATA_WIDTH(32)) m_if();
  axi_stream_if #(.DATA_WIDTH(8))  s8_if();
  axi_stream_if #(.DATA_WIDTH(8))  m8_if();
  axis_ascii_int_parser #(.VALUE_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if));
  axis_ascii_int_parser #(.VALUE_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .s_axis(s8_if), .m_axis(m8_if));
  assign s8_if.tvalid = s_if.tvalid;
  assign s8_if.tdata  = s_if.tdata;
  assign s8_if.tlast  = s_if.tlast;
  assign m8_if.tready = m_if.tready;
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [32:0] exp32_q[$];
  logic [8:0]  exp8_q[$];
  int rmode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    ph++;
    m_if.tready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
  end
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, prev_word});
      if (m_if.tvalid && m_if.tready) begin
        check("beat_expected32", exp32_q.size() != 0, 1);
        if (exp32_q.size() != 0) check("beat32", {m_if.tlast, m_if.tdata}, exp32_q.pop_front());
      end
      if (m8_if.tvalid && m8_if.tready) begin
        check("beat_expected8", exp8_q.size() != 0, 1);
        if (exp8_q.size() != 0) check("beat8", {m8_if.tlast, m8_if.tdata}, exp8_q.pop_front());
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word  = {m_if.tlast, m_if.tdata};
    end
  end
  function automatic bq_t to_q(string str);
    bq_t q;
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    return q;
  endfunction
  // splits a whole frame into its numbers and queues the beats both widths must produce
  task automatic model(bq_t q);
    logic [31:0] a32 = '0;
    logic [7:0]  a8 = '0;
    logic [31:0] v32[$];
    logic [7:0]  v8[$];
    bit          in_num = 0, neg = 0, pend = 0;
    logic [7:0]  c;
    for (int i = 0; i <= q.size(); i++) begin
      c = i < q.size() ? 8'(q[i]) : 8'h00;
      if (i < q.size() && c >= 8'h30 && c <= 8'h39) begin
        if (!in_num) begin
          neg  = pend;
          pend = 0;
        end
        a32    = a32 * 32'd10 + 32'(c - 8'h30);
        a8     = a8 * 8'd10 + (c - 8'h30);
        in_num = 1;
      end else begin
        if (in_num) begin
          v32.push_back(neg ? 32'd0 - a32 : a32);
          v8.push_back(neg ? 8'd0 - a8 : a8);
        end
        a32    = '0;
        a8     = '0;
        in_num = 0;
        neg    = 0;
`ifdef AXIS_INT_PARSER_SIGNED_EN
        pend   = c == 8'h2D;
`endif
      end
    end
    for (int i = 0; i < v32.size(); i++) begin
      exp32_q.push_back({i == v32.size() - 1, v32[i]});
      exp8_q.push_back({i == v8.size() - 1, v8[i]});
    end
  endtask
  task automatic send(bq_t q, bit do_last, bit gaps, output int stalls);
    int w;
    stalls = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = q[i];
      s_if.tlast  = do_last && i == q.size() - 1;
      w = 0;
      @(negedge clk);
      while (!s_if.tready && w < 200) begin
        stalls++;
        w++;
        @(negedge clk);
      end
      check("byte_accept", s_if.tready, 1);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while ((exp32_q.size() != 0 || exp8_q.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("drain32", exp32_q.size(), 0);
    check("drain8", exp8_q.size(), 0);
    check("idle_valid", m_if.tvalid, 0);
  endtask
  task automatic frame(bq_t q, bit gaps);
    int st;
    model(q);
    send(q, 1, gaps, st);
    drain();
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int  st;
    bq_t q;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_s_tready", s_if.tready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rmode = 0;
    q = to_q("12,345\n7");
    model(q);
    send(q, 1, 0, st);
    check("frame_stalls", st, 0);
    @(negedge clk);
    check("flush_bubble", s_if.tready, 0);
    @(negedge clk);
    check("flush_done", s_if.tready, 1);
    drain();
    frame(to_q("42\n"), 0);
    frame(to_q("\n\n"), 0);
    frame(to_q("9"), 0);
    frame(to_q("300 5"), 0);
    rmode = 1;
    frame(to_q("1 2 3 4 5"), 0);
    rmode = 0;
    send(to_q("123 45"), 0, 0, st);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_s_tready", s_if.tready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(to_q("6"), 0);
    frame(to_q("-5 3-2 --7 a-b"), 0);
    for (int f = 0; f < 60; f++) begin
      bq_t r;
      int  n;
      rmode = $urandom_range(0, 2);
      n = $urandom_range(1, 24);
      for (int j = 0; j < n; j++) begin
        int k = $urandom_range(0, 9);
        if ($urandom_range(0, 15) == 0) repeat (12) r.push_back(byte'(8'h30 + $urandom_range(0, 9)));
        r.push_back(k < 5 ? byte'(8'h30 + $urandom_range(0, 9)) : k == 5 ? " " : k == 6 ? "," : k == 7 ? "\n" : k == 8 ? "-" : "x");
      end
      frame(r, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axis_ascii_int_parser.md
Name: axis_ascii_int_parser

Overview:
- Stream consumer/producer pair. The slave end takes an 8-bit ASCII character stream (puzzle input text, one frame per file); the master end emits parsed unsigned decimal integers, one per beat.
- Output tlast marks the last integer of the input frame.
- Sits directly behind the byte source, ahead of the puzzle compute blocks.

Parameters:
- VALUE_WIDTH, 32, width of the emitted integer (m_axis DATA_WIDTH).

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- rst_n  input  1  synchronous reset, active-low.
- s_axis  axi_stream_if.slave  DATA_WIDTH=8  ASCII byte input: tvalid/tdata/tlast in, tready out.
- m_axis  axi_stream_if.master  DATA_WIDTH=VALUE_WIDTH  parsed integer output: tvalid/tdata/tlast out, tready in.

Behaviour:
- Interface: one clock, clk; reset rst_n, synchronous and active-low.
- Transfer occurs on a cycle where tvalid && tready. m_axis tvalid, once high, holds with tdata/tlast stable until accepted.
- Reset values: m_axis tvalid=0, tdata=0, tlast=0; s_axis tready=0 while rst_n=0. Internal state: accumulator=0, in_num=0, hold_valid=0, state=RUN.
- Reset mid-frame discards any partial number and the held value; nothing is emitted for them.
- Storage: accumulator acc[VALUE_WIDTH-1:0], flag in_num, hold register hold/hold_valid (last completed number, not yet emitted), output register.
- Holding back one value is the only way to place tlast on the final integer.
- Digit byte ('0'..'9', 0x30..0x39):
  - acc <= acc*10 + (byte-0x30), truncated modulo 2^VALUE_WIDTH (silent wrap);
  - in_num <= 1.
- Any other byte: if in_num, the number completes; then acc <= 0, in_num <= 0.
- A number in progress also completes on a tlast byte. If that byte is a digit, the digit is included first.
- Completion, non-tlast byte:
  - hold_valid=1: output <= hold (tlast 0), hold <= new value.
  - hold_valid=0: hold <= new value, hold_valid <= 1.
- tlast byte, after any completion; then acc <= 0, in_num <= 0:
  - hold_valid and new value: output <= hold (tlast 0), hold <= new, go to FLUSH.
  - hold_valid, no new value: output <= hold (tlast 1), hold_valid <= 0.
  - no hold, new value: output <= new (tlast 1).
  - neither: nothing emitted; an empty frame produces no output beat.
- States:
  - RUN: s_axis tready = (!m_axis tvalid || m_axis tready).
  - FLUSH: s_axis tready = 0. When the output slot is free, output <= hold (tlast 1), hold_valid <= 0, go to RUN.
- Latency: a value appears on m_axis the cycle after the byte that completes the following number, or the cycle after the frame's tlast byte. It appears in FLUSH one cycle after the slot frees.
- Back-to-back: with m_axis tready held high, one byte is accepted every cycle, except the single FLUSH bubble per frame.
- Consecutive separators (e.g. "\n\n", ", ") are harmless: no empty values.

Optional Feature:
- Macro: AXIS_INT_PARSER_SIGNED_EN.
- Defined:
  - '-' (0x2D) received while in_num=0 sets neg_pending.
  - '-' while in_num=1 completes the number, then sets neg_pending.
  - Any other non-digit clears neg_pending.
  - The first digit latches neg <= neg_pending and clears neg_pending.
  - Completed value = neg ? (0 - acc) : acc, two's complement, VALUE_WIDTH bits.
  - neg clears on completion and on tlast.
- Undefined: '-' is an ordinary separator; all values unsigned; no neg state is synthesised.

Test Plan:
- Frame "12,345\n7" with tlast on '7', m_axis tready=1 -> beats 12(tlast0), 345(tlast0), 7(tlast1); exactly one cycle with s_axis tready=0 (FLUSH).
- Frame "42\n" with tlast on '\n' -> single beat 42 tlast1; frame "\n\n" with tlast -> no beats; next frame "9" with tlast -> 9 tlast1.
- VALUE_WIDTH=8, frame "300 5" with tlast -> 44 (300 mod 256) tlast0, 5 tlast1.
- Frame "1 2 3 4 5" with tlast, m_axis tready toggling 1,0,0,1 repeating -> beats 1,2,3,4,5 in order, tlast only on 5; tdata stable while stalled; no byte lost.
- rst_n low for 1 cycle after "123 45" (no tlast), then frame "6" with tlast -> only beat 6 tlast1; m_axis tvalid=0 and s_axis tready=0 during reset.
- With AXIS_INT_PARSER_SIGNED_EN, frame "-5 3-2 --7 a-b" with tlast -> 0xFFFFFFFB, 3, 0xFFFFFFFE, 0xFFFFFFF9(tlast1).
  - Same frame without the macro -> 5, 3, 2, 7(tlast1).
